left_rot_seq: RTL and testbench
===============================

# left_rot_seq

Sequential left-rotate unit: accepts a WIDTH-bit word and a rotate amount over a valid/ready handshake. It rotates the word left by one position per clock. It presents the result over a second valid/ready handshake. It is the left-direction counterpart of the team's right-rotate datapath and sits between a word producer and a consumer that may apply backpressure.

## Interface
Parameters:
- WIDTH, 4, data word width in bits (≥2)
- AW, $clog2(WIDTH), width of the rotate-amount field (derived; not overridden)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer presents din/amt
- in_ready  output  1  block can accept a word
- din  input  WIDTH  word to rotate
- amt  input  AW  left-rotate amount, 0..WIDTH-1
- out_valid  output  1  dout holds a finished result
- out_ready  input  1  consumer takes the result
- dout  output  WIDTH  rotated word
- busy  output  1  high whenever state ≠ IDLE

## Operation
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- FSM states: IDLE, ROT, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: data_q←din, cnt_q←amt.
  - Next state is ROT if amt≠0, else OUT.
- ROT:
  - in_ready=0. Each cycle: data_q←{data_q[WIDTH-2:0], data_q[WIDTH-1]} and cnt_q←cnt_q−1.
  - When cnt_q==1 at the edge, that rotation is the last one; next state is OUT.
- OUT:
  - out_valid=1 and dout=data_q, held stable until out_ready.
  - On out_valid&out_ready, next state is IDLE.
  - in_ready=0 in OUT; there is no same-cycle turnaround.
- in_ready is asserted only in IDLE, so an input handshake can never coincide with ROT or OUT.
- Arithmetic:
  - Rotation is modulo WIDTH; bits are never lost.
  - cnt_q is AW bits and never underflows, because ROT is entered only with cnt_q≥1.
- Inputs are ignored outside an input handshake. din and amt may change freely while in_ready=0.
- dout outside OUT: it shows the data_q register (don't-care to the consumer). The bench checks dout only while out_valid=1.

## Timing
- Reset (async assert, any state, including mid-ROT or in OUT with out_ready low):
  - state→IDLE, data_q=0, cnt_q=0.
  - in_ready=1, out_valid=0, busy=0, dout=0.
  - Any in-flight word is discarded.
- Reset deassertion: synchronous-safe. The first input handshake is possible on the first rising edge with rst_n=1.
- Latency: the input handshake occurs in cycle 0; out_valid is first high in cycle amt+1.
  - amt=0 → cycle 1.
  - amt=WIDTH−1 → cycle WIDTH.
- Backpressure: out_valid stays high and dout stays constant for every cycle out_ready=0. There is no timeout.
- Throughput: one word per amt+2 cycles minimum, counting the IDLE cycle needed for the next accept.
- busy equals (state≠IDLE) combinationally from the state register.
- in_ready and out_valid are decoded from the state only, never from inputs. There are no combinational in→out paths.

## Structure
- Package left_rot_pkg holds:
  - the state enum typedef (IDLE, ROT, OUT);
  - localparam default WIDTH=4.
- Sub-module left_rot1 is a purely combinational single-position left rotate of WIDTH bits. It is instantiated once, feeding data_q's next value in ROT.
- The top module contains the FSM, cnt_q, data_q and the handshake decode.

## Test plan
- Reset then din=0001, amt=1 → out_valid in cycle 2, dout=0010; in_ready back to 1 the cycle after out_ready.
- din=1000, amt=1 → dout=0001 (MSB wraps to LSB).
- din=1011, amt=3 → out_valid in cycle 4, dout=1101; busy high cycles 1–4.
- din=0110, amt=0 → out_valid in cycle 1, dout=0110.
- din=0011, amt=2 with out_ready=0 for 5 cycles:
  - dout=1100 is held steady with out_valid=1;
  - in_valid pulses during this window are not accepted (in_ready=0).
- din=0101, amt=3, rst_n driven low mid-ROT:
  - all outputs are immediately at reset values (out_valid=0, dout=0, in_ready=1);
  - after release, a new din=0001, amt=2 completes with dout=0100.

Source files
------------

// File: rtl/left_rot_pkg.sv
// Shared types and defaults for the sequential left-rotate unit.
package left_rot_pkg;

    // Default data word width.
    localparam int unsigned DEF_WIDTH = 4;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/left_rot1.sv
// Single-position left rotate: the MSB wraps around into the LSB.
module left_rot1 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // One-bit left rotate, purely combinational.
    assign dout = {din[WIDTH-2:0], din[WIDTH-1]};

endmodule

// File: rtl/left_rot_seq.sv
// Sequential left-rotate unit: rotates one bit position per clock,
// with valid/ready handshakes on both the input and the output side.
module left_rot_seq
    import left_rot_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [AW-1:0]    cnt_q;
    logic [AW-1:0]    cnt_d;
    logic [WIDTH-1:0] rot_data;

    // Datapath step: data_q rotated left by one position.
    left_rot1 #(
        .WIDTH (WIDTH)
    ) u_rot1 (
        .din  (data_q),
        .dout (rot_data)
    );

    // State, word and remaining-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, datapath update and handshake decode from the state register.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = din;
                    cnt_d   = amt;
                    // A zero amount skips straight to presenting the word.
                    state_d = (amt != '0) ? ROT : OUT;
                end
            end
            ROT: begin
                data_d = rot_data;
                cnt_d  = cnt_q - AW'(1);
                // ROT is only entered with cnt_q >= 1, so this never wraps.
                if (cnt_q == AW'(1)) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result word is the data register itself; stable while held in OUT.
    assign dout = data_q;

endmodule

// File: tb/tb_left_rot_seq.sv
// Scoreboard bench for left_rot_seq: the driver pushes hand-computed results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_left_rot_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] din;
    logic [1:0] amt;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] dout;
    logic       busy;

    typedef struct {
        logic [3:0] data;
        int         exp_cyc;
        bit         seen;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   idle_chk = 0;

    left_rot_seq #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .amt       (amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: compares the presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            idle_chk = 0;
        end else begin
            if (idle_chk) begin
                chk("idle_in_ready", int'(in_ready), 1);
                chk("idle_busy", int'(busy), 0);
                idle_chk = 0;
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got dout=0x%0h expected no output at cycle %0d",
                             dout, cyc);
                end else begin
                    if (!q[0].seen) begin
                        chk("latency", cyc, q[0].exp_cyc);
                        q[0].seen = 1;
                    end
                    chk("dout", int'(dout), int'(q[0].data));
                    if (out_ready) begin
                        void'(q.pop_front());
                        idle_chk = 1;
                    end
                end
            end
        end
    end

    // Offer one word; on acceptance push the expected result and output cycle.
    task automatic send(input logic [3:0] d, input logic [1:0] a, input logic [3:0] e);
        bit acc = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        din      = d;
        amt      = a;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                q.push_back('{data: e, exp_cyc: cyc + int'(a) + 1, seen: 1'b0});
            end
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din      = '0;
        amt      = '0;
    endtask

    // Wait until every pushed result has been consumed, bounded.
    task automatic wait_done();
        int i;
        for (i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din       = '0;
        amt       = '0;

        // Reset state
        #3;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dout", int'(dout), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Basic rotate by one
        send(4'b0001, 2'd1, 4'b0010);
        wait_done();

        // MSB wraps into LSB
        send(4'b1000, 2'd1, 4'b0001);
        wait_done();

        // Maximum amount; busy through ROT and OUT
        send(4'b1011, 2'd3, 4'b1101);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("busy_rot_out", int'(busy), 1);
            chk("in_ready_busy", int'(in_ready), 0);
        end
        wait_done();

        // Zero amount passes through in one cycle
        send(4'b0110, 2'd0, 4'b0110);
        wait_done();

        send(4'b1001, 2'd2, 4'b0110);
        wait_done();

        // Backpressure: result held, new words refused
        out_ready = 1'b0;
        send(4'b0011, 2'd2, 4'b1100);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("bp_out_valid_seen", int'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            din      = 4'b1111;
            amt      = 2'd1;
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_done();
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of ROT
        send(4'b0101, 2'd3, 4'b1010);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_dout", int'(dout), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        send(4'b0001, 2'd2, 4'b0100);
        wait_done();
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
